// File: rtl/pool_seq_ctrl.sv
// pool_seq_ctrl: scans a row-major feature map in POOLxPOOL windows and streams each window max
// Ports: clk, rst_n (async active-low); start/busy/done pass control;
//        rd_en/rd_addr/rd_data feature-memory read port (1-cycle latency);
//        pool_clr/pool_en/pool_pix/pool_result pooling-unit interface;
//        out_valid/out_ready/out_data/out_addr pooled-pixel output stream.
module pool_seq_ctrl #(
  parameter int IMG_W  = 4,
  parameter int IMG_H  = 4,
  parameter int POOL   = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              pool_clr,
  output logic              pool_en,
  output logic [DATA_W-1:0] pool_pix,
  input  logic [DATA_W-1:0] pool_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr
);
  localparam int OUT_W = IMG_W / POOL;
  localparam int OUT_H = IMG_H / POOL;
  localparam logic [1:0] PL = 2'(POOL - 1);
  localparam logic [ADDR_W-1:0] OWL  = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] OHL  = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ROW  = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(POOL);
  localparam logic [ADDR_W-1:0] BAND = ADDR_W'(POOL * IMG_W);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, WRITE, DONE} state_t;

  state_t            state;
  logic [1:0]        wx, wy;
  logic [ADDR_W-1:0] ox, oy;
  // org: current window origin address; orow: origin of the current window band; row: current row start
  logic [ADDR_W-1:0] org, orow, row;
  logic              last_win;

  assign last_win = (ox == OWL) && (oy == OHL);
  assign pool_pix = rd_data;
  assign out_data = pool_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      pool_clr  <= 1'b0;
      pool_en   <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      wx        <= '0;
      wy        <= '0;
      ox        <= '0;
      oy        <= '0;
      org       <= '0;
      orow      <= '0;
      row       <= '0;
    end else begin
      // read data returns one cycle after the strobe, so the enable trails rd_en by one cycle
      pool_en <= rd_en;
      case (state)
        IDLE: if (start) begin
          state    <= CLEAR;
          busy     <= 1'b1;
          pool_clr <= 1'b1;
          ox       <= '0;
          oy       <= '0;
          org      <= '0;
          orow     <= '0;
          out_addr <= '0;
        end
        CLEAR: begin
          state    <= FETCH;
          pool_clr <= 1'b0;
          rd_en    <= 1'b1;
          rd_addr  <= org;
          row      <= org;
          wx       <= '0;
          wy       <= '0;
        end
        FETCH: if (wx == PL) begin
          wx <= '0;
          if (wy == PL) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            wy      <= wy + 2'd1;
            row     <= row + ROW;
            rd_addr <= row + ROW;
          end
        end else begin
          wx      <= wx + 2'd1;
          rd_addr <= rd_addr + 1'b1;
        end
        DRAIN: begin
          state     <= WRITE;
          out_valid <= 1'b1;
        end
        WRITE: if (out_ready) begin
          out_valid <= 1'b0;
          out_addr  <= last_win ? '0 : out_addr + 1'b1;
          ox        <= (ox == OWL) ? '0 : ox + 1'b1;
          oy        <= (ox == OWL) ? oy + 1'b1 : oy;
          orow      <= (ox == OWL) ? orow + BAND : orow;
          org       <= (ox == OWL) ? orow + BAND : org + STEP;
          state     <= last_win ? DONE : CLEAR;
          done      <= last_win;
          pool_clr  <= !last_win;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pool_seq_ctrl.md
Name: pool_seq_ctrl

Overview:
- Sequencer for the max-pooling datapath (pooling unit with clear, enable and pixel inputs and a held max output).
- Scans a row-major feature map in a single-port read memory with non-overlapping POOLxPOOL windows, stride POOL.
- For each window: clears the pooling unit, streams the window's pixels into it, then emits the window maximum on a valid/ready output stream with an output-map address.
- Sits between the conv feature-map buffer and the pooled-map buffer.

Parameters:
IMG_W, 4, input feature-map width in pixels (>= POOL)
IMG_H, 4, input feature-map height in pixels (>= POOL)
POOL, 2, window edge and stride (2..4)
DATA_W, 16, pixel width
ADDR_W, 10, read/write address width; must cover IMG_W*IMG_H

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; starts one full-map pass when idle
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse at end of pass
rd_en  out  1  feature-memory read strobe
rd_addr  out  ADDR_W  feature-memory read address
rd_data  in  DATA_W  read data, valid exactly 1 cycle after rd_en
pool_clr  out  1  to pooling unit block-change/clear input
pool_en  out  1  to pooling unit compare-enable input
pool_pix  out  DATA_W  to pooling unit pixel input
pool_result  in  DATA_W  pooling unit held max output
out_valid  out  1  pooled pixel valid
out_ready  in  1  downstream accept
out_data  out  DATA_W  pooled pixel (= pool_result while out_valid)
out_addr  out  ADDR_W  pooled-map index, row-major, 0-based

Behaviour:
- Reset (rst_n low, any time, mid-pass included): state IDLE; all counters 0; busy, done, rd_en, pool_clr, pool_en, out_valid = 0; rd_addr, out_addr = 0. No partial window is written afterwards.
- OUT_W = IMG_W/POOL, OUT_H = IMG_H/POOL (floor). Trailing columns/rows beyond OUT_W*POOL / OUT_H*POOL are never read.
- States: IDLE, CLEAR, FETCH, DRAIN, WRITE, DONE.
- IDLE: start=1 -> CLEAR. Window origin = (0,0); out_addr = 0.
- CLEAR (1 cycle): pool_clr=1 -> FETCH.
- FETCH (POOL*POOL cycles): rd_en=1 every cycle. Addresses visit the window row-major: wx fastest, then wy.
  - rd_addr = (oy*POOL+wy)*IMG_W + ox*POOL + wx, formed by running base/offset adders, no multiplier.
  - After the last read -> DRAIN.
- Pooling-unit feed: pool_en = registered rd_en; pool_pix = rd_data. Exactly POOL*POOL enable cycles per window, none during CLEAR.
- DRAIN (1 cycle): carries the last pool_en -> WRITE.
- WRITE: out_valid=1, out_data=pool_result, out_addr stable; held until out_ready=1.
  - Handshake cycle: out_addr increments (wraps to 0 at pass end).
  - Origin advances ox+1; at OUT_W it wraps to 0 and oy+1.
  - Last window -> DONE, else -> CLEAR.
- DONE (1 cycle): done=1 -> IDLE.
- busy=1 in all states except IDLE.
- Backpressure: while out_valid=1 and out_ready=0, no read is issued and pool_clr/pool_en stay 0, so pool_result is frozen.
- start while busy is ignored. start in the same cycle as done is ignored (FSM is in DONE).
- Latency: start sampled in IDLE at cycle 0 -> first pool_clr at cycle 1.
  - With out_ready tied high, each window takes POOL*POOL+3 cycles.
  - done is high at cycle 1 + OUT_W*OUT_H*(POOL*POOL+3).
- Pixels are unsigned; the controller does not alter data.

Test Plan:
- 4x4 map, pix[i]=i, POOL=2, out_ready=1 -> outputs (addr,data) = (0,5),(1,7),(2,13),(3,15); done at cycle 29 after start; busy low at cycle 30.
- Window 0 address trace, same map -> rd_addr 0,1,4,5; pool_en high on the 4 cycles following those reads; pool_clr exactly once before each window.
- 5x5 map, POOL=2 -> 4 outputs; rd_addr never equals 4, 9, 14, 19 or 20..24; data (0,6),(1,8),(2,16),(3,18).
- out_ready low for 5 cycles on window 1 -> out_valid and out_data=7 held steady; rd_en, pool_en and pool_clr stay 0 during the stall; remaining windows correct.
- start pulsed at cycles 3 and 10 of a pass -> ignored; exactly 4 outputs and one done pulse.
- rst_n low during FETCH of window 2 -> all outputs 0 next cycle; a fresh start then produces the full 4-output sequence from out_addr 0.
